// File: rtl/reg_file_sb_pkg.sv
// rtl/reg_file_sb_pkg.sv - default parameters and width helpers for reg_file_sb
package reg_file_sb_pkg;

    localparam int DEF_NUM_RS    = 3;
    localparam int DEF_NUM_RD    = 2;
    localparam int DEF_ZERO_REG  = 1;
    localparam int DEF_NUM_REG   = 32;
    localparam int DEF_REG_WIDTH = 32;

    // Count must reach NUM_REG itself, hence the +1.
    function automatic int busy_cnt_w(input int num_reg);
        return $clog2(num_reg + 1);
    endfunction

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// rtl/reg_file_sb_scoreboard.sv - busy bits, reservation stall and busy count (REG_FILE_SB_BYPASS_EN)
module reg_file_sb_scoreboard
    import reg_file_sb_pkg::*;
#(
    parameter int NUM_RS   = DEF_NUM_RS,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int NUM_REG  = DEF_NUM_REG,
    localparam int AW      = $clog2(NUM_REG),
    localparam int CW      = busy_cnt_w(NUM_REG)
)(
    input  logic                        clk_i,
    input  logic                        arst_ni,
    input  logic [NUM_RD-1:0]           wr_ok_i,
    input  logic [NUM_RD-1:0][AW-1:0]   rd_addr_i,
    input  logic [NUM_RS-1:0][AW-1:0]   rs_addr_i,
    input  logic [AW-1:0]               lock_addr_i,
    input  logic                        lock_en_i,
    output logic [NUM_RS-1:0]           rs_busy_o,
    output logic                        lock_stall_o,
    output logic [CW-1:0]               busy_cnt_o
);

    logic [NUM_REG-1:0] busy_q;
    logic [NUM_REG-1:0] busy_d;
    logic [CW-1:0]      cnt_d;
    logic               lock_wr_hit;
    logic               lock_ok;

    always_comb begin
        lock_wr_hit = 1'b0;
        for (int j = 0; j < NUM_RD; j++) begin
            if (wr_ok_i[j] && rd_addr_i[j] == lock_addr_i) lock_wr_hit = 1'b1;
        end
        lock_stall_o = lock_en_i && busy_q[lock_addr_i] && !lock_wr_hit;
        lock_ok      = lock_en_i && !lock_stall_o && ((ZERO_REG == 0) || (lock_addr_i != '0));

        // Writes release first so a same-cycle lock re-reserves the register.
        busy_d = busy_q;
        for (int j = 0; j < NUM_RD; j++) begin
            if (wr_ok_i[j]) busy_d[rd_addr_i[j]] = 1'b0;
        end
        if (lock_ok) busy_d[lock_addr_i] = 1'b1;

        cnt_d = '0;
        for (int i = 0; i < NUM_REG; i++) cnt_d = cnt_d + CW'(busy_d[i]);
    end

    always_comb begin
        for (int i = 0; i < NUM_RS; i++) begin
            rs_busy_o[i] = busy_q[rs_addr_i[i]];
`ifdef REG_FILE_SB_BYPASS_EN
            for (int j = 0; j < NUM_RD; j++) begin
                if (wr_ok_i[j] && rd_addr_i[j] == rs_addr_i[i]) rs_busy_o[i] = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            busy_q     <= '0;
            busy_cnt_o <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_o <= cnt_d;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - multi-port register file with busy scoreboard (REG_FILE_SB_BYPASS_EN)
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int NUM_RS    = DEF_NUM_RS,
    parameter int NUM_RD    = DEF_NUM_RD,
    parameter int ZERO_REG  = DEF_ZERO_REG,
    parameter int NUM_REG   = DEF_NUM_REG,
    parameter int REG_WIDTH = DEF_REG_WIDTH,
    localparam int AW       = $clog2(NUM_REG),
    localparam int CW       = busy_cnt_w(NUM_REG)
)(
    input  logic                             clk_i,
    input  logic                             arst_ni,
    input  logic [NUM_RD-1:0][AW-1:0]        rd_addr_i,
    input  logic [NUM_RD-1:0][REG_WIDTH-1:0] rd_data_i,
    input  logic [NUM_RD-1:0]                rd_en_i,
    input  logic [NUM_RS-1:0][AW-1:0]        rs_addr_i,
    output logic [NUM_RS-1:0][REG_WIDTH-1:0] rs_data_o,
    output logic [NUM_RS-1:0]                rs_busy_o,
    input  logic [AW-1:0]                    lock_addr_i,
    input  logic                             lock_en_i,
    output logic                             lock_stall_o,
    output logic [CW-1:0]                    busy_cnt_o
);

    logic [REG_WIDTH-1:0] mem_q [NUM_REG];
    logic [NUM_RD-1:0]    wr_ok;

    // Gated by reset so a bypassed write cannot leak onto the read ports while held.
    always_comb begin
        for (int j = 0; j < NUM_RD; j++) begin
            wr_ok[j] = arst_ni && rd_en_i[j] && ((ZERO_REG == 0) || (rd_addr_i[j] != '0));
        end
    end

    // Ascending port order makes the highest-index writer the last assignment.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int i = 0; i < NUM_REG; i++) mem_q[i] <= '0;
        end else begin
            for (int j = 0; j < NUM_RD; j++) begin
                if (wr_ok[j]) mem_q[rd_addr_i[j]] <= rd_data_i[j];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_RS; i++) begin
            rs_data_o[i] = mem_q[rs_addr_i[i]];
`ifdef REG_FILE_SB_BYPASS_EN
            for (int j = 0; j < NUM_RD; j++) begin
                if (wr_ok[j] && rd_addr_i[j] == rs_addr_i[i]) rs_data_o[i] = rd_data_i[j];
            end
`endif
            if ((ZERO_REG != 0) && (rs_addr_i[i] == '0)) rs_data_o[i] = '0;
        end
    end

    reg_file_sb_scoreboard #(
        .NUM_RS   (NUM_RS),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG),
        .NUM_REG  (NUM_REG)
    ) u_scoreboard (
        .clk_i        (clk_i),
        .arst_ni      (arst_ni),
        .wr_ok_i      (wr_ok),
        .rd_addr_i    (rd_addr_i),
        .rs_addr_i    (rs_addr_i),
        .lock_addr_i  (lock_addr_i),
        .lock_en_i    (lock_en_i),
        .rs_busy_o    (rs_busy_o),
        .lock_stall_o (lock_stall_o),
        .busy_cnt_o   (busy_cnt_o)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed and reference-model checks for reg_file_sb (REG_FILE_SB_BYPASS_EN)
module tb_reg_file_sb;

`ifdef REG_FILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk_i = 1'b0;
    logic             arst_ni;
    logic [1:0][4:0]  rd_addr;
    logic [1:0][31:0] rd_data;
    logic [1:0]       rd_en;
    logic [2:0][4:0]  rs_addr;
    logic [2:0][31:0] rs_data;
    logic [2:0]       rs_busy;
    logic [4:0]       lock_addr;
    logic             lock_en;
    logic             lock_stall;
    logic [5:0]       busy_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_mem [32];
    bit          m_busy [32];

    always #5 clk_i = ~clk_i;

    reg_file_sb dut (
        .clk_i        (clk_i),
        .arst_ni      (arst_ni),
        .rd_addr_i    (rd_addr),
        .rd_data_i    (rd_data),
        .rd_en_i      (rd_en),
        .rs_addr_i    (rs_addr),
        .rs_data_o    (rs_data),
        .rs_busy_o    (rs_busy),
        .lock_addr_i  (lock_addr),
        .lock_en_i    (lock_en),
        .lock_stall_o (lock_stall),
        .busy_cnt_o   (busy_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        rd_en   = '0;
        lock_en = 1'b0;
    endtask

    task automatic wr(input int port, input logic [4:0] a, input logic [31:0] d);
        rd_en[port]   = 1'b1;
        rd_addr[port] = a;
        rd_data[port] = d;
    endtask

    function automatic int model_cnt();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    initial begin
        logic [31:0] exp_d;
        bit          exp_b;
        bit          exp_s;
        bit          hit;

        arst_ni = 1'b0;
        idle();
        rd_addr = '0; rd_data = '0; rs_addr = '0; lock_addr = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rs_addr[0] = 5'd5; lock_en = 1'b1; lock_addr = 5'd3;
        #1;
        check("rst_data", rs_data[0], 32'h0);
        check("rst_busy", {29'b0, rs_busy}, 32'h0);
        check("rst_cnt", {26'b0, busy_cnt}, 32'h0);
        check("rst_stall", {31'b0, lock_stall}, 32'h0);
        idle();
        arst_ni = 1'b1;
        tick();

        // single write then read back
        wr(0, 5'd5, 32'hDEADBEEF); rs_addr[0] = 5'd5;
        #1;
        check("wr5_same_cycle", rs_data[0], BYP ? 32'hDEADBEEF : 32'h0);
        tick(); idle();
        #1;
        check("wr5_read", rs_data[0], 32'hDEADBEEF);

        // two ports on one address: port 1 wins
        wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22);
        tick(); idle(); rs_addr[1] = 5'd7;
        #1;
        check("wr7_priority", rs_data[1], 32'h22);

        // lock, refused relock, release by write
        lock_en = 1'b1; lock_addr = 5'd3; rs_addr[2] = 5'd3;
        #1;
        check("lock3_stall0", {31'b0, lock_stall}, 32'h0);
        tick(); idle();
        #1;
        check("lock3_busy", {31'b0, rs_busy[2]}, 32'h1);
        check("lock3_cnt", {26'b0, busy_cnt}, 32'd1);
        lock_en = 1'b1; lock_addr = 5'd3;
        #1;
        check("relock3_stall", {31'b0, lock_stall}, 32'h1);
        tick(); idle();
        #1;
        check("relock3_cnt", {26'b0, busy_cnt}, 32'd1);
        wr(1, 5'd3, 32'h33);
        #1;
        check("rel3_busy_same", {31'b0, rs_busy[2]}, BYP ? 32'h0 : 32'h1);
        tick(); idle();
        #1;
        check("rel3_busy", {31'b0, rs_busy[2]}, 32'h0);
        check("rel3_cnt", {26'b0, busy_cnt}, 32'd0);
        check("rel3_data", rs_data[2], 32'h33);

        // lock and write together: lock wins
        lock_en = 1'b1; lock_addr = 5'd3; wr(0, 5'd3, 32'h5);
        tick(); idle();
        #1;
        check("lw3_data", rs_data[2], 32'h5);
        check("lw3_busy", {31'b0, rs_busy[2]}, 32'h1);
        check("lw3_cnt", {26'b0, busy_cnt}, 32'd1);
        // relock while busy is not refused when a write to it is present
        lock_en = 1'b1; lock_addr = 5'd3; wr(1, 5'd3, 32'h6);
        #1;
        check("lw3b_stall", {31'b0, lock_stall}, 32'h0);
        tick(); idle();
        #1;
        check("lw3b_data", rs_data[2], 32'h6);
        check("lw3b_cnt", {26'b0, busy_cnt}, 32'd1);
        wr(0, 5'd3, 32'h7);
        tick(); idle();

        // register zero
        wr(0, 5'd0, 32'hFFFF); lock_en = 1'b1; lock_addr = 5'd0; rs_addr[0] = 5'd0;
        #1;
        check("r0_stall", {31'b0, lock_stall}, 32'h0);
        check("r0_data_same", rs_data[0], 32'h0);
        tick(); idle();
        #1;
        check("r0_data", rs_data[0], 32'h0);
        check("r0_busy", {31'b0, rs_busy[0]}, 32'h0);
        check("r0_cnt", {26'b0, busy_cnt}, 32'd0);

        // bypass vs stored value
        wr(0, 5'd9, 32'h55);
        tick(); idle();
        wr(1, 5'd9, 32'hA5); rs_addr[1] = 5'd9;
        #1;
        check("byp9_same", rs_data[1], BYP ? 32'hA5 : 32'h55);
        tick(); idle();
        #1;
        check("byp9_after", rs_data[1], 32'hA5);

        // async reset mid-run, with traffic discarded during reset
        lock_en = 1'b1; lock_addr = 5'd12;
        tick(); idle(); rs_addr[0] = 5'd5; rs_addr[2] = 5'd12;
        arst_ni = 1'b0;
        #1;
        check("arst_cnt", {26'b0, busy_cnt}, 32'd0);
        check("arst_data", rs_data[0], 32'h0);
        check("arst_busy", {31'b0, rs_busy[2]}, 32'h0);
        wr(0, 5'd5, 32'h1234); lock_en = 1'b1; lock_addr = 5'd12;
        #1;
        check("arst_byp", rs_data[0], 32'h0);
        tick(); tick(); idle();
        arst_ni = 1'b1;
        #1;
        check("arst_drop_wr", rs_data[0], 32'h0);
        check("arst_drop_lock", {31'b0, rs_busy[2]}, 32'h0);
        tick();

        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end

        for (int c = 0; c < 1000; c++) begin
            for (int j = 0; j < 2; j++) begin
                rd_en[j]   = 1'($urandom_range(0, 1));
                rd_addr[j] = 5'($urandom_range(0, 7));
                rd_data[j] = $urandom;
            end
            lock_en   = 1'($urandom_range(0, 1));
            lock_addr = 5'($urandom_range(0, 7));
            for (int i = 0; i < 3; i++) rs_addr[i] = 5'($urandom_range(0, 7));
            #1;
            check("rnd_cnt", {26'b0, busy_cnt}, 32'(model_cnt()));
            for (int i = 0; i < 3; i++) begin
                exp_d = (rs_addr[i] == 5'd0) ? 32'h0 : m_mem[rs_addr[i]];
                exp_b = m_busy[rs_addr[i]];
                if (BYP) begin
                    for (int j = 0; j < 2; j++) begin
                        if (rd_en[j] && rd_addr[j] == rs_addr[i] && rd_addr[j] != 5'd0) begin
                            exp_d = rd_data[j];
                            exp_b = 1'b0;
                        end
                    end
                end
                check("rnd_data", rs_data[i], exp_d);
                check("rnd_busy", {31'b0, rs_busy[i]}, {31'b0, exp_b});
            end
            hit = 1'b0;
            for (int j = 0; j < 2; j++) begin
                if (rd_en[j] && rd_addr[j] == lock_addr) hit = 1'b1;
            end
            exp_s = lock_en && m_busy[lock_addr] && !hit;
            check("rnd_stall", {31'b0, lock_stall}, {31'b0, exp_s});
            for (int j = 0; j < 2; j++) begin
                if (rd_en[j] && rd_addr[j] != 5'd0) begin
                    m_mem[rd_addr[j]]  = rd_data[j];
                    m_busy[rd_addr[j]] = 1'b0;
                end
            end
            if (lock_en && !exp_s && lock_addr != 5'd0) m_busy[lock_addr] = 1'b1;
            tick();
        end
        idle();
        #1;
        check("rnd_final_cnt", {26'b0, busy_cnt}, 32'(model_cnt()));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter NUM_RS, default 3, number of read ports.
REQ-002 SHALL have parameter NUM_RD, default 2, number of write ports.
REQ-003 SHALL have parameter ZERO_REG, default 1: register 0 reads zero, ignores writes, never busy.
REQ-004 SHALL have parameter NUM_REG, default 32, register count, power of two >= 2; AW = $clog2(NUM_REG).
REQ-005 SHALL have parameter REG_WIDTH, default 32, data width.
REQ-006 SHALL have clk_i  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have arst_ni  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have rd_addr_i  input  [NUM_RD][AW]  write addresses.
REQ-009 SHALL have rd_data_i  input  [NUM_RD][REG_WIDTH]  write data.
REQ-010 SHALL have rd_en_i  input  [NUM_RD]  write enables.
REQ-011 SHALL have rs_addr_i  input  [NUM_RS][AW]  read addresses.
REQ-012 SHALL have rs_data_o  output  [NUM_RS][REG_WIDTH]  read data.
REQ-013 SHALL have rs_busy_o  output  [NUM_RS]  read register has a pending producer.
REQ-014 SHALL have lock_addr_i  input  AW  destination to reserve at issue.
REQ-015 SHALL have lock_en_i  input  1  reservation request.
REQ-016 SHALL have lock_stall_o  output  1  reservation refused this cycle.
REQ-017 SHALL have busy_cnt_o  output  $clog2(NUM_REG+1)  registered count of busy registers.

Function
REQ-018 Reads SHALL be combinational from array; rs_data_o and rs_busy_o zero for register 0 when ZERO_REG=1.
REQ-019 Write port j SHALL update rd_addr_i[j] on rising edge when rd_en_i[j]=1 and address writable.
REQ-020 Two or more ports writing one address same cycle: highest port index SHALL win.
REQ-021 Accepted write SHALL clear that register's busy bit at same edge.
REQ-022 lock_stall_o SHALL be 1 when lock_en_i=1, lock_addr_i busy, and no write to lock_addr_i this cycle; else 0.
REQ-023 Accepted lock (lock_en_i=1, lock_stall_o=0, writable address) SHALL set busy bit at next edge.
REQ-024 Lock and write to same address same cycle: lock SHALL win (busy stays 1, data updated).
REQ-025 Lock to register 0 with ZERO_REG=1 SHALL be accepted, have no effect, never stall.
REQ-026 busy_cnt_o SHALL equal number of set busy bits after each edge; 0..NUM_REG, no wrap.

Reset
REQ-027 arst_ni low SHALL immediately clear all registers, all busy bits and busy_cnt_o; rs_data_o=0, rs_busy_o=0, lock_stall_o=0 while low.
REQ-028 Writes and locks during reset SHALL be discarded; first update on first edge after release.

Configuration
REQ-029 Macro REG_FILE_SB_BYPASS_EN defined: read of a register written same cycle SHALL return highest-index write data and rs_busy_o=0 (lock same cycle ignored for rs_busy_o).
REQ-030 Macro undefined: reads SHALL return pre-edge stored value and stored busy bit.

Structure
REQ-031 Package reg_file_sb_pkg SHALL hold default parameter constants and busy-count width function.
REQ-032 Scoreboard (busy bits, stall, count) SHALL be sub-module reg_file_sb_scoreboard; data array in top.

Verification
REQ-033 Reset, write port0 reg5=0xDEADBEEF -> next cycle rs_data_o[0]=0xDEADBEEF for rs_addr 5.
REQ-034 Port0 and port1 both write reg7 (0x11, 0x22) -> reg7 reads 0x22.
REQ-035 Lock reg3 -> rs_busy_o=1, busy_cnt_o=1; second lock reg3 -> lock_stall_o=1; write reg3 -> busy clear, busy_cnt_o=0.
REQ-036 Lock reg3 and write reg3=0x5 same cycle -> reg3 reads 0x5, still busy, busy_cnt_o=1.
REQ-037 Write reg0=0xFFFF and lock reg0 with ZERO_REG=1 -> reads 0, busy 0, no stall.
REQ-038 Bypass build: write reg9=0xA5 while reading reg9 -> same cycle rs_data_o=0xA5; non-bypass -> old value; 1000-cycle random run vs reference model, zero mismatches.
